// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pipeline_hazard_ctrl                                          |
// | Purpose  : Stall/flush producer for the five-stage pipeline latches,     |
// |            with data-memory wait/halt FSM and saturating event counters. |
// |            Build option FORWARDING_EN: only load-use hazards stall.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       id_rs,
  input  logic [1:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             idex_regwrite,
  input  logic             idex_memread,
  input  logic [1:0]       idex_dest,
  input  logic             exmem_regwrite,
  input  logic             memwb_regwrite,
  input  logic [1:0]       exmem_dest,
  input  logic [1:0]       memwb_dest,
  input  logic             id_jump,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             dmem_ready,
  input  logic             wb_halt,
  output logic             pc_write,
  output logic             ifid_stall_on,
  output logic             ifid_flush_on,
  output logic             idex_flush_on,
  output logic             pipe_freeze,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0]       c_RUN   = 2'd0;
  localparam logic [1:0]       c_DWAIT = 2'd1;
  localparam logic [1:0]       c_HALT  = 2'd2;
  localparam logic [CNT_W-1:0] c_CMAX  = {CNT_W{1'b1}};

  logic [1:0] r_state;
  logic [1:0] w_state_next;
  logic       w_match_idex;
  logic       w_match_exmem;
  logic       w_match_memwb;
  logic       w_hazard;
  logic       w_frozen;

  assign w_match_idex  = (id_use_rs && (id_rs == idex_dest))  || (id_use_rt && (id_rt == idex_dest));
  assign w_match_exmem = (id_use_rs && (id_rs == exmem_dest)) || (id_use_rt && (id_rt == exmem_dest));
  assign w_match_memwb = (id_use_rs && (id_rs == memwb_dest)) || (id_use_rt && (id_rt == memwb_dest));

`ifdef FORWARDING_EN
  assign w_hazard = idex_regwrite && idex_memread && w_match_idex;
  logic w_unused_fwd;
  assign w_unused_fwd = ^{exmem_regwrite, memwb_regwrite, w_match_exmem, w_match_memwb};
`else
  assign w_hazard = (idex_regwrite  && w_match_idex)  ||
                    (exmem_regwrite && w_match_exmem) ||
                    (memwb_regwrite && w_match_memwb);
`endif

  // The cycle in which memory reports ready already gets RUN outputs.
  assign w_frozen = (r_state == c_HALT) || ((r_state == c_DWAIT) && !dmem_ready);

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) r_state <= c_RUN;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (wb_halt) begin
      w_state_next = c_HALT;
    end else begin
      case (r_state)
        c_RUN:   if (mem_req && !dmem_ready) w_state_next = c_DWAIT;
        c_DWAIT: if (dmem_ready)             w_state_next = c_RUN;
        c_HALT:  w_state_next = c_HALT;
        default: w_state_next = c_RUN;
      endcase
    end
  end

  always_comb begin
    pc_write      = 1'b1;
    ifid_stall_on = 1'b0;
    ifid_flush_on = 1'b0;
    idex_flush_on = 1'b0;
    pipe_freeze   = 1'b0;
    halted        = (r_state == c_HALT);
    if (w_frozen || (mem_req && !dmem_ready && !ex_redirect)) begin
      pc_write      = 1'b0;
      ifid_stall_on = 1'b1;
      pipe_freeze   = 1'b1;
    end else if (ex_redirect) begin
      ifid_flush_on = 1'b1;
      idex_flush_on = 1'b1;
    end else if (w_hazard) begin
      pc_write      = 1'b0;
      ifid_stall_on = 1'b1;
      idex_flush_on = 1'b1;
    end else if (id_jump) begin
      ifid_flush_on = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (r_state != c_HALT) begin
      if (!pc_write && (stall_cnt != c_CMAX))
        stall_cnt <= stall_cnt + 1'b1;
      if ((ifid_flush_on || idex_flush_on) && (flush_cnt != c_CMAX))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// Bench for pipeline_hazard_ctrl: directed vectors, a rule-level model checked
// every cycle, and literal expectations at the interesting points.
module tb_pipeline_hazard_ctrl;
  localparam int CNT_W = 3;
  localparam int MAXC  = (1 << CNT_W) - 1;
`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int WALK = FWD ? 0 : 3;
  localparam int FL_SAT = (3 + WALK + 3 > MAXC) ? MAXC : 3 + WALK + 3;

  logic clk = 1'b0;
  logic reset_n;
  logic [1:0] id_rs, id_rt, idex_dest, exmem_dest, memwb_dest;
  logic id_use_rs, id_use_rt, idex_regwrite, idex_memread, exmem_regwrite, memwb_regwrite;
  logic id_jump, ex_redirect, mem_req, dmem_ready, wb_halt;
  logic pc_write, ifid_stall_on, ifid_flush_on, idex_flush_on, pipe_freeze, halted;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .idex_regwrite(idex_regwrite), .idex_memread(idex_memread), .idex_dest(idex_dest),
    .exmem_regwrite(exmem_regwrite), .memwb_regwrite(memwb_regwrite),
    .exmem_dest(exmem_dest), .memwb_dest(memwb_dest),
    .id_jump(id_jump), .ex_redirect(ex_redirect), .mem_req(mem_req),
    .dmem_ready(dmem_ready), .wb_halt(wb_halt),
    .pc_write(pc_write), .ifid_stall_on(ifid_stall_on), .ifid_flush_on(ifid_flush_on),
    .idex_flush_on(idex_flush_on), .pipe_freeze(pipe_freeze), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: halted / waiting-on-memory flags and plain integer counters.
  bit m_halt, m_wait;
  int m_stall, m_flush;

  function automatic bit hazard();
    logic [1:0] d [3];
    bit         w [3];
    bit         hit;
    d = '{idex_dest, exmem_dest, memwb_dest};
    w = '{idex_regwrite && (!FWD || idex_memread), !FWD && exmem_regwrite, !FWD && memwb_regwrite};
    hit = 1'b0;
    for (int k = 0; k < 3; k++)
      if (w[k] && ((id_use_rs && id_rs == d[k]) || (id_use_rt && id_rt == d[k]))) hit = 1'b1;
    return hit;
  endfunction

  // {pc_write, ifid_stall_on, ifid_flush_on, idex_flush_on, pipe_freeze}
  function automatic logic [4:0] exp_ctl();
    if (m_halt || (m_wait && !dmem_ready)) return 5'b01001;
    if (ex_redirect)                       return 5'b10110;
    if (mem_req && !dmem_ready)            return 5'b01001;
    if (hazard())                          return 5'b01010;
    if (id_jump)                           return 5'b10100;
    return 5'b10000;
  endfunction

  always @(posedge clk or posedge reset_n) begin : model
    logic [4:0] e;
    if (reset_n) begin
      m_halt = 0; m_wait = 0; m_stall = 0; m_flush = 0;
    end else begin
      e = exp_ctl();
      if (!m_halt) begin
        if (!e[4] && m_stall < MAXC) m_stall++;
        if ((e[2] || e[1]) && m_flush < MAXC) m_flush++;
      end
      if (wb_halt) m_halt = 1;
      else if (!m_halt) m_wait = m_wait ? !dmem_ready : (mem_req && !dmem_ready);
    end
  end

  always @(negedge clk) begin : compare
    logic [4:0] e;
    e = exp_ctl();
    check("pc_write",      pc_write,      e[4]);
    check("ifid_stall_on", ifid_stall_on, e[3]);
    check("ifid_flush_on", ifid_flush_on, e[2]);
    check("idex_flush_on", idex_flush_on, e[1]);
    check("pipe_freeze",   pipe_freeze,   e[0]);
    check("halted",        halted,        m_halt);
    check("stall_cnt",     stall_cnt,     m_stall);
    check("flush_cnt",     flush_cnt,     m_flush);
  end

  task automatic idle();
    id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    idex_regwrite = 0; idex_memread = 0; idex_dest = 0;
    exmem_regwrite = 0; memwb_regwrite = 0; exmem_dest = 0; memwb_dest = 0;
    id_jump = 0; ex_redirect = 0; mem_req = 0; dmem_ready = 0; wb_halt = 0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs(input bit allow_halt);
    id_rs = 2'($urandom); id_rt = 2'($urandom);
    id_use_rs = 1'($urandom); id_use_rt = 1'($urandom);
    idex_regwrite = 1'($urandom); idex_memread = 1'($urandom); idex_dest = 2'($urandom);
    exmem_regwrite = 1'($urandom); memwb_regwrite = 1'($urandom);
    exmem_dest = 2'($urandom); memwb_dest = 2'($urandom);
    id_jump = 1'($urandom); ex_redirect = ($urandom_range(0, 3) == 0);
    mem_req = 1'($urandom); dmem_ready = ($urandom_range(0, 3) != 0) || ex_redirect;
    wb_halt = allow_halt ? 1'($urandom) : 1'b0;
  endtask

  initial begin
    idle();
    reset_n = 1;
    repeat (2) @(posedge clk);
    #1 reset_n = 0;
    @(negedge clk);
    check("rst_pc_write", pc_write, 1);
    check("rst_ifid_stall", ifid_stall_on, 0);
    check("rst_halted", halted, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_flush_cnt", flush_cnt, 0);

    // Load-use on rs=2: one stall cycle in either build.
    next();
    idex_regwrite = 1; idex_memread = 1; idex_dest = 2; id_rs = 2; id_use_rs = 1;
    @(negedge clk);
    check("lu_pc_write", pc_write, 0);
    check("lu_ifid_stall", ifid_stall_on, 1);
    check("lu_idex_flush", idex_flush_on, 1);
    next();
    idex_regwrite = 0; idex_memread = 0;
    @(negedge clk);
    check("lu_release_pc", pc_write, 1);
    check("lu_stall_cnt", stall_cnt, 1);

    // ALU producer of r0 walking down the pipe, consumer reads rt=0.
    next();
    id_use_rs = 0; id_use_rt = 1; id_rt = 0; idex_regwrite = 1; idex_dest = 0;
    @(negedge clk); check("walk_idex_pc", pc_write, FWD);
    next();
    idex_regwrite = 0; exmem_regwrite = 1; exmem_dest = 0;
    @(negedge clk); check("walk_exmem_pc", pc_write, FWD);
    next();
    exmem_regwrite = 0; memwb_regwrite = 1; memwb_dest = 0;
    @(negedge clk); check("walk_memwb_pc", pc_write, FWD);
    next();
    memwb_regwrite = 0;
    @(negedge clk);
    check("walk_done_pc", pc_write, 1);
    check("walk_stall_cnt", stall_cnt, 1 + WALK);

    // Unused source field must not match.
    next();
    id_use_rt = 0; idex_regwrite = 1; idex_memread = 1; idex_dest = 0;
    @(negedge clk); check("nouse_pc", pc_write, 1);

    // Redirect wins over load-use and jump.
    next();
    id_use_rt = 1; ex_redirect = 1; id_jump = 1;
    @(negedge clk);
    check("redir_pc", pc_write, 1);
    check("redir_ifid_flush", ifid_flush_on, 1);
    check("redir_idex_flush", idex_flush_on, 1);
    check("redir_ifid_stall", ifid_stall_on, 0);
    next();
    idle();
    @(negedge clk);
    check("redir_flush_cnt", flush_cnt, 2 + WALK);
    check("redir_stall_cnt", stall_cnt, 1 + WALK);

    next();
    id_jump = 1;
    @(negedge clk);
    check("jmp_ifid_flush", ifid_flush_on, 1);
    check("jmp_idex_flush", idex_flush_on, 0);
    check("jmp_pc", pc_write, 1);
    next();
    id_jump = 0;
    @(negedge clk); check("jmp_flush_cnt", flush_cnt, 3 + WALK);

    // Memory wait: four frozen cycles, ready cycle gets RUN outputs.
    next();
    mem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("dw_freeze", pipe_freeze, 1);
      check("dw_pc", pc_write, 0);
      next();
    end
    dmem_ready = 1;
    @(negedge clk);
    check("dw_exit_freeze", pipe_freeze, 0);
    check("dw_exit_pc", pc_write, 1);
    next();
    idle();

    // Held load-use pushes counters into saturation.
    idex_regwrite = 1; idex_memread = 1; idex_dest = 1; id_rs = 1; id_use_rs = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); check("sat_pc", pc_write, 0);
      next();
    end
    idle();
    @(negedge clk);
    check("sat_stall_cnt", stall_cnt, MAXC);
    check("sat_flush_cnt", flush_cnt, FL_SAT);

    // Halt arriving during DWAIT, then sticky against random inputs.
    next();
    mem_req = 1; dmem_ready = 0;
    next();
    wb_halt = 1;
    @(negedge clk); check("halt_pre", halted, 0);
    next();
    wb_halt = 0;
    @(negedge clk); check("halt_set", halted, 1);
    for (int i = 0; i < 8; i++) begin
      next();
      rand_inputs(1'b1);
      @(negedge clk);
      check("halt_sticky", halted, 1);
      check("halt_freeze", pipe_freeze, 1);
      check("halt_ifid_flush", ifid_flush_on, 0);
      check("halt_stall_cnt", stall_cnt, MAXC);
    end

    // Asynchronous reset out of HALT.
    next();
    idle();
    #2 reset_n = 1;
    #1;
    check("areset_halted", halted, 0);
    check("areset_stall_cnt", stall_cnt, 0);
    check("areset_flush_cnt", flush_cnt, 0);
    check("areset_pc", pc_write, 1);
    next();
    reset_n = 0;

    // Reset in DWAIT drops the pending freeze.
    mem_req = 1; dmem_ready = 0;
    next();
    mem_req = 0;
    @(negedge clk);
    check("rdw_freeze_pre", pipe_freeze, 1);
    #2 reset_n = 1;
    #1;
    check("rdw_freeze", pipe_freeze, 0);
    check("rdw_pc", pc_write, 1);
    next();
    reset_n = 0;

    for (int i = 0; i < 60; i++) begin
      rand_inputs(1'b0);
      next();
    end
    idle();
    next();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and pipeline-control unit for the 16-bit five-stage pipeline. It drives the stall and flush controls consumed by the IF/ID, ID/EX, EX/MEM and MEM/WB latches. It is the producer end of the stall/flush protocol those latches implement. The unit detects data hazards, control redirects, data-memory wait states and program halt, runs a small state machine for multi-cycle conditions, and keeps saturating performance counters.

## Interface
Parameters:
- CNT_W, 16, width of the stall and flush counters

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  reset, asynchronous, active-high
- id_rs, id_rt  in  2 each  source register fields of the instruction in ID
- id_use_rs, id_use_rt  in  1 each  ID instruction actually reads rs / rt
- idex_regwrite, idex_memread  in  1 each  ID/EX instruction writes the RF / is a load
- idex_dest  in  2  ID/EX destination register
- exmem_regwrite, memwb_regwrite  in  1 each  EX/MEM and MEM/WB instruction writes the RF
- exmem_dest, memwb_dest  in  2 each  destination registers
- id_jump  in  1  JMP/JAL/JPR/JRL resolved in ID, target valid
- ex_redirect  in  1  branch in EX resolved opposite to the fetched path
- mem_req  in  1  EX/MEM instruction accesses data memory this cycle
- dmem_ready  in  1  data memory completes the access this cycle
- wb_halt  in  1  HLT instruction is in WB and valid
- pc_write  out  1  PC may load its next value
- ifid_stall_on  out  1  IF/ID holds its instruction
- ifid_flush_on  out  1  IF/ID content is invalidated
- idex_flush_on  out  1  ID/EX receives a bubble
- pipe_freeze  out  1  ID/EX, EX/MEM and MEM/WB hold their contents
- halted  out  1  processor halted
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters

## Operation
- FSM states:
  - RUN=0
  - DWAIT=1
  - HALT=2
- FSM transitions:
  - RUN→DWAIT when mem_req & !dmem_ready.
  - DWAIT→RUN when dmem_ready.
  - Any state→HALT when wb_halt. HALT has priority over DWAIT entry.
  - HALT is sticky until reset.
- In DWAIT and HALT:
  - pc_write=0, ifid_stall_on=1, pipe_freeze=1.
  - All flush outputs=0.
  - Hazard detection is masked.
- In RUN, priority is highest first:
  1. ex_redirect: ifid_flush_on=1, idex_flush_on=1, pc_write=1, ifid_stall_on=0. A simultaneous load-use stall and id_jump are discarded.
  2. mem_req & !dmem_ready: outputs take DWAIT values in the same cycle (freeze is combinational). The state register moves to DWAIT at the next edge.
  3. Data hazard: pc_write=0, ifid_stall_on=1, idex_flush_on=1.
  4. id_jump: ifid_flush_on=1, pc_write=1.
  5. Otherwise: pc_write=1 and all other controls 0.
- A match means (id_use_rs & id_rs==X) | (id_use_rt & id_rt==X), where X is a destination field.
- Data hazard, with forwarding (see Configuration): idex_regwrite & idex_memread & match(idex_dest).
- Data hazard, without forwarding: any of the following.
  - idex_regwrite & match(idex_dest)
  - exmem_regwrite & match(exmem_dest)
  - memwb_regwrite & match(memwb_dest)
- Register 0 is a normal register; matches on it count.
- stall_cnt increments on every cycle with pc_write=0 while the state is RUN or DWAIT.
- flush_cnt increments on every cycle in which ifid_flush_on or idex_flush_on is asserted.
- Both counters saturate at 2^CNT_W−1. They do not count in HALT.
- halted=1 exactly when the state is HALT.

## Timing
- All control outputs are combinational from the state and current inputs. They take effect at the latch edge of the same cycle.
- FSM and counters are registered. A counter value reflects events up to the previous edge.
- Reset values:
  - state=RUN
  - stall_cnt=0, flush_cnt=0, halted=0
  - With inputs idle: pc_write=1 and all other controls 0.
- Reset asserted mid-DWAIT or in HALT returns to RUN immediately. A pending freeze is dropped.
- Load-use stall (forwarding build) lasts exactly 1 cycle. The load advances to EX/MEM, so the hazard clears.
- DWAIT length equals the number of cycles until dmem_ready, plus 0 extra cycles. The exit-cycle outputs are RUN values.

## Configuration
- FORWARDING_EN defined: EX/MEM and MEM/WB are forwarded by the datapath, so only load-use hazards stall.
- FORWARDING_EN undefined: ID stalls until every producer is past WB, for a maximum of 3 stall cycles per dependency.

## Test plan
- Load-use, FORWARDING_EN defined:
  - Stimulus: idex_memread=1, idex_regwrite=1, idex_dest=2, id_rs=2, id_use_rs=1.
  - Response: pc_write=0, ifid_stall_on=1, idex_flush_on=1 for 1 cycle; stall_cnt 0→1.
- Same dependency on an ALU producer, FORWARDING_EN undefined:
  - Stimulus: the producer walks ID/EX→EX/MEM→MEM/WB.
  - Response: 3 consecutive stall cycles, then pc_write=1; stall_cnt=3.
- ex_redirect=1 with a simultaneous load-use hazard and id_jump=1:
  - Response: ifid_flush_on=1, idex_flush_on=1, pc_write=1; flush_cnt +1 only.
- Data-memory wait:
  - Stimulus: mem_req=1, dmem_ready low for 4 cycles.
  - Response: pipe_freeze=1 and pc_write=0 for 4 cycles; state DWAIT for 3 edges; RUN on ready.
- Halt:
  - Stimulus: wb_halt=1 during DWAIT.
  - Response: halted=1 next edge; stays 1 with all inputs toggling.
  - Then: asserting reset_n clears halted and the counters asynchronously.
